// File: rtl/sr_universal_reg_if.sv
// rtl/sr_universal_reg_if.sv - control, data and frame-status bundle for sr_universal_reg
interface sr_universal_reg_if #(
    parameter int WIDTH = 8
);
    logic             write;
    logic [1:0]       mode;
    logic [WIDTH-1:0] inp;
    logic             sin;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             busy;
    logic             done;

    modport master (
        output write, mode, inp, sin,
        input  q, sout, busy, done
    );

    modport slave (
        input  write, mode, inp, sin,
        output q, sout, busy, done
    );
endinterface

// File: rtl/sr_universal_reg.sv
// rtl/sr_universal_reg.sv - universal shift register: hold/load/shift-in/PISO frame (SR_UNIV_PARITY_EN adds even parity bit)
module sr_universal_reg #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    sr_universal_reg_if.slave bus
);
`ifdef SR_UNIV_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic             done_reg, done_next;
    logic             fill;

`ifdef SR_UNIV_PARITY_EN
    // Parity rides into q as the first zero-fill bit, so it leaves sout right after the LSB.
    logic par, par_next;
    assign fill = par;
`else
    assign fill = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            q_reg    <= RST_VAL;
            cnt      <= '0;
            done_reg <= 1'b0;
`ifdef SR_UNIV_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            q_reg    <= q_next;
            cnt      <= cnt_next;
            done_reg <= done_next;
`ifdef SR_UNIV_PARITY_EN
            par      <= par_next;
`endif
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.write && bus.mode == 2'b11) state_next = SHIFT;
            SHIFT:   if (cnt == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        q_next    = q_reg;
        cnt_next  = cnt;
        done_next = 1'b0;
`ifdef SR_UNIV_PARITY_EN
        par_next  = par;
`endif
        case (state)
            IDLE: begin
                if (bus.write) begin
                    case (bus.mode)
                        2'b01: q_next = bus.inp;
                        2'b10: q_next = {q_reg[WIDTH-2:0], bus.sin};
                        2'b11: begin
                            q_next   = bus.inp;
                            cnt_next = CW'(FRAME - 1);
`ifdef SR_UNIV_PARITY_EN
                            par_next = ^bus.inp;
`endif
                        end
                        default: q_next = q_reg;
                    endcase
                end
            end
            SHIFT: begin
                q_next = {q_reg[WIDTH-2:0], fill};
`ifdef SR_UNIV_PARITY_EN
                par_next = 1'b0;
`endif
                if (cnt == '0) done_next = 1'b1;
                else           cnt_next  = cnt - CW'(1);
            end
            default: q_next = q_reg;
        endcase
    end

    assign bus.q    = q_reg;
    assign bus.sout = q_reg[WIDTH-1];
    assign bus.busy = (state == SHIFT);
    assign bus.done = done_reg;
endmodule
